// File: rtl/ntt_index_gen.sv
// Address/twiddle sequencer for an in-place radix-2 NTT: walks every butterfly of
// every stage, one beat per valid/ready handshake, forward (half grows) or inverse.
module ntt_index_gen #(
   parameter int LOG_N = 4
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          start,
   input  logic                                          inv,
   input  logic                                          ready,
   output logic                                          valid,
   output logic [(($clog2(LOG_N) > 1) ? $clog2(LOG_N) : 1)-1:0] stage,
   output logic [LOG_N-1:0]                              addr_a,
   output logic [LOG_N-1:0]                              addr_b,
   output logic [LOG_N-2:0]                              tw_idx,
   output logic                                          last,
   output logic                                          busy,
   output logic                                          done
);

   localparam int SW = ($clog2(LOG_N) > 1) ? $clog2(LOG_N) : 1;
   localparam int KW = LOG_N - 1;
   localparam logic [SW-1:0] LAST_STAGE = SW'(LOG_N - 1);
   localparam logic [KW-1:0] LAST_K     = '1;
   localparam logic [SW:0]   TOP_LH     = (SW + 1)'(LOG_N - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t          r_state;
   logic            r_mode;
   logic [SW-1:0]   r_stage;
   logic [KW-1:0]   r_k;
   logic            r_done;

   logic            w_run;
   logic            w_last;
   logic [SW:0]     w_lh;
   logic [SW:0]     w_tsh;
   logic [LOG_N-1:0] w_h;
   logic [LOG_N-1:0] w_k_ext;
   logic [LOG_N-1:0] w_pos;
   logic [LOG_N-1:0] w_group;
   logic [LOG_N-1:0] w_addr_a;
   logic [LOG_N-1:0] w_tw_full;

   assign w_run  = (r_state == RUN);
   assign w_last = w_run && (r_stage == LAST_STAGE) && (r_k == LAST_K);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_mode  <= 1'b0;
         r_stage <= '0;
         r_k     <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= RUN;
                  r_mode  <= inv;
                  r_stage <= '0;
                  r_k     <= '0;
               end
            end
            RUN: begin
               if (ready) begin
                  if (w_last) begin
                     // stage/k return to zero so the idle outputs read as zero
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                     r_stage <= '0;
                     r_k     <= '0;
                  end else if (r_k == LAST_K) begin
                     r_k     <= '0;
                     r_stage <= r_stage + SW'(1);
                  end else begin
                     r_k <= r_k + KW'(1);
                  end
               end
            end
         endcase
      end
   end

   // lh is one bit wider than the stage so that lh+1 never wraps
   always_comb begin
      w_lh      = r_mode ? (TOP_LH - {1'b0, r_stage}) : {1'b0, r_stage};
      w_tsh     = TOP_LH - w_lh;
      w_h       = LOG_N'(1) << w_lh;
      w_k_ext   = {1'b0, r_k};
      w_pos     = w_k_ext & (w_h - LOG_N'(1));
      w_group   = w_k_ext >> w_lh;
      w_addr_a  = (w_group << (w_lh + (SW + 1)'(1))) | w_pos;
      w_tw_full = w_pos << w_tsh;
   end

   assign valid  = w_run;
   assign busy   = w_run;
   assign done   = r_done;
   assign last   = w_last;
   assign stage  = r_stage;
   assign addr_a = w_run ? w_addr_a : '0;
   assign addr_b = w_run ? (w_addr_a + w_h) : '0;
   assign tw_idx = w_run ? w_tw_full[LOG_N-2:0] : '0;

endmodule

// File: doc/ntt_index_gen.md
NTT_INDEX_GEN -- requirements
Module: ntt_index_gen

Interface
REQ-001 The block SHALL have parameter LOG_N, default 4, meaning log2 of the transform size N = 2^LOG_N; legal range 2..12.
REQ-002 The block SHALL derive localparam SW = max(1, clog2(LOG_N)), the stage index width.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port start  input  1  request a new pass; sampled only in IDLE.
REQ-006 The block SHALL have port inv  input  1  mode, captured with start: 0 = forward (half grows), 1 = inverse (half shrinks).
REQ-007 The block SHALL have port ready  input  1  consumer accepts the current beat.
REQ-008 The block SHALL have port valid  output  1  addr_a, addr_b, tw_idx, stage and last are valid.
REQ-009 The block SHALL have port stage  output  SW  current stage s, 0..LOG_N-1.
REQ-010 The block SHALL have port addr_a  output  LOG_N  butterfly upper operand address.
REQ-011 The block SHALL have port addr_b  output  LOG_N  butterfly lower operand address.
REQ-012 The block SHALL have port tw_idx  output  LOG_N-1  twiddle ROM index.
REQ-013 The block SHALL have port last  output  1  current beat is the final beat of the pass.
REQ-014 The block SHALL have port busy  output  1  a pass is in progress.
REQ-015 The block SHALL have port done  output  1  single-cycle pulse on completion of a pass.

Function
REQ-016 FSM states SHALL be IDLE and RUN. IDLE->RUN on start=1; RUN->IDLE on the handshake of the last beat.
REQ-017 On IDLE with start=1, at the next edge: inv SHALL be latched into mode_r, stage=0, k=0, busy=1, valid=1.
REQ-018 In RUN, valid SHALL be 1 and busy SHALL be 1.
REQ-019 A beat SHALL advance only on valid&&ready; when ready=0 all outputs SHALL hold their values.
REQ-020 The butterfly counter k SHALL run 0..N/2-1 per stage; at k=N/2-1 with a handshake, k wraps to 0 and stage increments.
REQ-021 Half-size h SHALL be 2^stage when mode_r=0, and 2^(LOG_N-1-stage) when mode_r=1; let lh = log2(h).
REQ-022 Outputs SHALL be: group = k>>lh, pos = k & (h-1), addr_a = (group<<(lh+1)) | pos, addr_b = addr_a + h, tw_idx = pos<<(LOG_N-1-lh), truncated to LOG_N-1 bits.
REQ-023 Outputs SHALL be registered or derived from registered state only; no combinational path from ready or start to any output.
REQ-024 last SHALL equal valid && stage==LOG_N-1 && k==N/2-1.
REQ-025 One pass SHALL be exactly LOG_N*N/2 handshakes.
REQ-026 On the handshake of the last beat, at the next edge: valid=0, busy=0, done=1 for exactly one cycle.
REQ-027 start SHALL be ignored while busy=1, including the cycle in which last is handshaked.
REQ-028 start=1 in the cycle done=1 SHALL begin a new pass, so that valid rises the following cycle.
REQ-029 inv changes during RUN SHALL have no effect on the current pass.
REQ-030 In IDLE, valid, busy and done SHALL be 0; addr_a, addr_b, tw_idx and stage SHALL be 0.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for a clock edge, force IDLE, mode_r=0, stage=0, k=0 and all outputs to 0.
REQ-032 Assertion of rst mid-pass SHALL abort the pass with no done pulse; after rst is released, the next start SHALL begin a fresh pass from stage 0, k=0.

Verification (LOG_N=3, N=8 unless stated)
REQ-033 Forward pass: start with inv=0 and ready=1 held high -> the bench SHALL check beats (a,b,tw) for stage0 (0,1,0),(2,3,0),(4,5,0),(6,7,0); stage1 (0,2,0),(1,3,2),(4,6,0),(5,7,2); stage2 (0,4,0),(1,5,1),(2,6,2),(3,7,3); last only on the 12th beat; done pulses once, one cycle after the 12th beat.
REQ-034 Inverse pass: start with inv=1 -> the bench SHALL check that stage0 runs (0,4,0)..(3,7,3) and stage2 runs (0,1,0)..(6,7,0); 12 beats total.
REQ-035 Backpressure: drive ready with a random pattern -> the bench SHALL check the same 12-beat sequence as REQ-033 with no beat skipped or duplicated, and outputs stable while ready=0.
REQ-036 Asynchronous reset: assert rst between edges mid-stage1 -> the bench SHALL check that outputs clear before the next edge and no done pulse occurs; a subsequent start SHALL restart at (0,1,0).
REQ-037 Start handling: assert start during RUN -> the bench SHALL check that it is ignored; assert start in the done cycle -> the bench SHALL check back-to-back passes with one idle cycle between them.
REQ-038 LOG_N=4: the bench SHALL check 32 beats, last stage beat k=7 giving (7,15,7).
